sdp_ram_be_pipe: RTL and testbench
==================================

SDP_RAM_BE_PIPE -- requirements
Module: sdp_ram_be_pipe

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: address bits; depth DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 Parameter BYTE_WIDTH, default 8: lane width; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH. A non-integer ratio SHALL be an elaboration error.
REQ-004 Parameter READ_LATENCY, default 1: 1 = registered read; 2 = additional output register. Any other value SHALL be an elaboration error.
REQ-005 Parameter RDW_MODE, default 0: same-address read-during-write result; 0 = old data, 1 = new data.
REQ-006 Parameter INIT_ON_RESET, default 1: 1 = zero-fill the whole array after reset; 0 = no fill.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 we  input  1  write request.
REQ-010 be  input  NUM_BYTES  per-lane write enable; bit i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-011 addr_w  input  ADDR_WIDTH  write address.
REQ-012 din  input  DATA_WIDTH  write data.
REQ-013 re  input  1  read request.
REQ-014 addr_r  input  ADDR_WIDTH  read address.
REQ-015 dout  output  DATA_WIDTH  read data, registered.
REQ-016 rd_valid  output  1  dout holds the result of a read on this cycle.
REQ-017 init_busy  output  1  zero-fill in progress; requests are ignored while it is high.

Function
REQ-018 FSM with two states: INIT and RUN. rst high SHALL force INIT with fill counter = 0 when INIT_ON_RESET=1, otherwise RUN.
REQ-019 In INIT, each cycle SHALL write all-zero data to address counter, then increment the counter; after the write to DEPTH-1, the next state SHALL be RUN. A fill SHALL take exactly DEPTH cycles.
REQ-020 init_busy SHALL be high exactly while the state is INIT. In INIT, we and re SHALL be ignored and rd_valid SHALL stay 0.
REQ-021 rst asserted mid-fill SHALL restart the fill at address 0.
REQ-022 In RUN, when we=1, each lane i with be[i]=1 SHALL take the matching din lane at the clock edge. Lanes with be[i]=0 SHALL be unchanged. we=1 with be=0 SHALL be a no-op.
REQ-023 In RUN, when re=1, the block SHALL sample addr_r. With READ_LATENCY=1, dout SHALL show the word and rd_valid SHALL be 1 after edge N+1. With READ_LATENCY=2, both SHALL appear after edge N+2.
REQ-024 rd_valid SHALL be 1 for exactly one cycle per accepted read. Back-to-back reads SHALL give one result per cycle with no bubbles.
REQ-025 When no read completes in a cycle, dout SHALL hold its last value and rd_valid SHALL be 0.
REQ-026 Same-edge read and write to the same address with RDW_MODE=0: the read SHALL return the contents before the write.
REQ-027 Same-edge read and write to the same address with RDW_MODE=1: the read SHALL return, per lane, din where be[i]=1 and old contents elsewhere.
REQ-028 Read and write to different addresses on the same edge SHALL not interact.
REQ-029 Every address value is legal; the array has no out-of-range addresses.

Reset
REQ-030 On rst: dout = 0, rd_valid = 0, all read pipeline stages = 0, init_busy = 1 when INIT_ON_RESET=1 and 0 otherwise. rst SHALL not clear the array directly; only the zero-fill does.
REQ-031 A read in flight when rst asserts SHALL be discarded; rd_valid SHALL not pulse for it.

Verification
REQ-032 Bench parameters ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8. Pulse rst for 1 cycle -> init_busy high for exactly 16 cycles. Then read every address -> each returns 0x00000000.
REQ-033 Write 0xAABBCCDD to address 3 with be=4'b1111. Then write 0x11223344 to address 3 with be=4'b0101. Read address 3 -> 0xAA22CC44.
REQ-034 READ_LATENCY=2: re=1 for 3 consecutive cycles at addresses 1, 2, 3 -> rd_valid high for 3 cycles starting 2 edges later, with data in order and no gaps.
REQ-035 Address 5 holds 0x0; same edge writes 0xFFFFFFFF with be=4'b0011 and reads address 5 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000FFFF.
REQ-036 Assert rst at fill counter 9 -> fill restarts at 0 and init_busy stays high for a further 16 cycles. A we pulse during the fill -> array unchanged, reads return 0.
REQ-037 Assert rst on the cycle after re=1 -> rd_valid never pulses for that read and dout = 0.

Source files
------------

// File: rtl/sdp_ram_be_pipe.sv
// Simple dual-port RAM with per-byte write enables, a 1- or 2-stage registered read
// pipeline, selectable read-during-write behaviour and an optional zero-fill after reset.
module sdp_ram_be_pipe #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned RDW_MODE      = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            addr_w,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            addr_r,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             rd_valid,
    output logic                             init_busy
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    // Reject unsupported parameterisations at elaboration.
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
        $error("sdp_ram_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("sdp_ram_be_pipe: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;

    logic                    mem_we_c;
    logic [NUM_BYTES-1:0]    mem_be_c;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;
    logic [DATA_WIDTH-1:0]   mem_din_c;
    logic                    rd_acc_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State register; init_busy mirrors the next state so it is a flop of its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
            fill_cnt_q <= '0;
            init_busy  <= (INIT_ON_RESET != 0);
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            init_busy  <= (state_d == S_INIT);
        end
    end

    // Next state and write-port steering: the fill owns the write port while in INIT.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        mem_we_c   = 1'b0;
        mem_be_c   = '0;
        mem_addr_c = addr_w;
        mem_din_c  = din;
        rd_acc_c   = 1'b0;
        case (state_q)
            S_INIT: begin
                mem_we_c   = 1'b1;
                mem_be_c   = '1;
                mem_addr_c = fill_cnt_q;
                mem_din_c  = '0;
                fill_cnt_d = ADDR_WIDTH'(fill_cnt_q + 1'b1);
                if (&fill_cnt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_we_c = we;
                mem_be_c = be;
                rd_acc_c = re;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Byte-lane write into the array; reset never touches the contents directly.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            for (int i = 0; i < int'(NUM_BYTES); i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_addr_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_din_c[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word, optionally forwarding enabled lanes of a same-address write.
    always_comb begin
        rd_word_c = mem[addr_r];
        if ((RDW_MODE != 0) && mem_we_c && (mem_addr_c == addr_r)) begin
            for (int i = 0; i < int'(NUM_BYTES); i++) begin
                if (mem_be_c[i]) begin
                    rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_din_c[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] p1_data;
    logic                  p1_valid;

    // First read stage; data holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_data  <= '0;
            p1_valid <= 1'b0;
        end else begin
            p1_valid <= rd_acc_c;
            if (rd_acc_c) begin
                p1_data <= rd_word_c;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] p2_data;
        logic                  p2_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                p2_data  <= '0;
                p2_valid <= 1'b0;
            end else begin
                p2_valid <= p1_valid;
                if (p1_valid) begin
                    p2_data <= p1_data;
                end
            end
        end

        assign dout     = p2_data;
        assign rd_valid = p2_valid;
    end else begin : g_lat1
        assign dout     = p1_data;
        assign rd_valid = p1_valid;
    end

endmodule

// File: tb/tb_sdp_ram_be_pipe.sv
// Scoreboard bench: two instances (latency 2 / old-data, latency 1 / new-data) share stimulus.
module tb_sdp_ram_be_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr_w;
    logic [31:0] din;
    logic        re;
    logic [3:0]  addr_r;
    logic [31:0] dout0, dout1;
    logic        rd_valid0, rd_valid1;
    logic        init_busy0, init_busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdp_ram_be_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                      .READ_LATENCY(2), .RDW_MODE(0), .INIT_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .we(we), .be(be), .addr_w(addr_w), .din(din),
        .re(re), .addr_r(addr_r), .dout(dout0), .rd_valid(rd_valid0), .init_busy(init_busy0));

    sdp_ram_be_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                      .READ_LATENCY(1), .RDW_MODE(1), .INIT_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .be(be), .addr_w(addr_w), .din(din),
        .re(re), .addr_r(addr_r), .dout(dout1), .rd_valid(rd_valid1), .init_busy(init_busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor for the latency-2 / old-data instance.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (rd_valid0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL u0 unexpected rd_valid at cycle %0d dout 0x%08h", cyc, dout0);
                end else begin
                    e = q0.pop_front();
                    if (dout0 !== e.d || cyc != e.due) begin
                        errors++;
                        $display("FAIL u0 read: got 0x%08h at cycle %0d expected 0x%08h at cycle %0d",
                                 dout0, cyc, e.d, e.due);
                    end
                end
            end else if (q0.size() > 0 && q0[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL u0 missing read: expected 0x%08h at cycle %0d", q0[0].d, q0[0].due);
                void'(q0.pop_front());
            end
        end
    end

    // Monitor for the latency-1 / new-data instance.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (rd_valid1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL u1 unexpected rd_valid at cycle %0d dout 0x%08h", cyc, dout1);
                end else begin
                    e = q1.pop_front();
                    if (dout1 !== e.d || cyc != e.due) begin
                        errors++;
                        $display("FAIL u1 read: got 0x%08h at cycle %0d expected 0x%08h at cycle %0d",
                                 dout1, cyc, e.d, e.due);
                    end
                end
            end else if (q1.size() > 0 && q1[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL u1 missing read: expected 0x%08h at cycle %0d", q1[0].d, q1[0].due);
                void'(q1.pop_front());
            end
        end
    end

    task automatic drive(input logic w, input logic [3:0] b, input logic [3:0] aw, input logic [31:0] d,
                         input logic r, input logic [3:0] ar, input logic push,
                         input logic [31:0] e0, input logic [31:0] e1);
        exp_t x;
        @(posedge clk);
        #1;
        we = w; be = b; addr_w = aw; din = d; re = r; addr_r = ar;
        if (push) begin
            x.d = e0; x.due = cyc + 2; q0.push_back(x);
            x.d = e1; x.due = cyc + 1; q1.push_back(x);
        end
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        drive(1'b1, b, a, d, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, 1'b1, e, e);
    endtask

    // One-cycle reset pulse; reads due after the reset edge are dropped from the scoreboard.
    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1; we = 1'b0; re = 1'b0; be = '0;
        while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("u0_init_busy_after_rst", 32'(init_busy0), 32'd1);
        chk("u1_init_busy_after_rst", 32'(init_busy1), 32'd1);
        chk("u0_rd_valid_after_rst", 32'(rd_valid0), 32'd0);
        chk("u1_rd_valid_after_rst", 32'(rd_valid1), 32'd0);
        chk("u0_dout_after_rst", dout0, 32'h0);
        chk("u1_dout_after_rst", dout1, 32'h0);
    endtask

    task automatic count_busy(input int exp);
        int n0 = 0;
        int n1 = 0;
        int guard = 0;
        while ((init_busy0 || init_busy1) && guard < 40) begin
            if (init_busy0) n0++;
            if (init_busy1) n1++;
            guard++;
            @(negedge clk);
        end
        chk("u0_init_busy_cycles", 32'(n0), 32'(exp));
        chk("u1_init_busy_cycles", 32'(n1), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; we = 1'b0; be = '0; addr_w = '0; din = '0; re = 1'b0; addr_r = '0;
        repeat (2) @(posedge clk);
        pulse_rst();
        started = 1'b1;
        check_reset_state();
        count_busy(16);

        // Freshly filled array reads back as zero, back-to-back.
        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
        repeat (3) idle();

        // Byte-lane merge and be=0 no-op.
        wr(4'd3, 4'b1111, 32'hAABBCCDD);
        wr(4'd3, 4'b0101, 32'h11223344);
        rd(4'd3, 32'hAA22CC44);
        wr(4'd3, 4'b0000, 32'hFFFFFFFF);
        rd(4'd3, 32'hAA22CC44);
        repeat (3) idle();

        // Three consecutive reads, in order, no gaps.
        wr(4'd1, 4'b1111, 32'h01010101);
        wr(4'd2, 4'b1111, 32'h02020202);
        rd(4'd1, 32'h01010101);
        rd(4'd2, 32'h02020202);
        rd(4'd3, 32'hAA22CC44);
        repeat (3) idle();

        // Same-address read during write: old data on u0, merged new data on u1.
        drive(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 1'b1, 32'h00000000, 32'h0000FFFF);
        rd(4'd5, 32'h0000FFFF);
        // Different addresses on the same edge do not interact.
        drive(1'b1, 4'b1111, 4'd6, 32'h12345678, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 32'hAA22CC44);
        rd(4'd6, 32'h12345678);
        repeat (3) idle();

        // Reset mid-fill at counter 9, with an ignored write/read pulse during the fill.
        pulse_rst();
        check_reset_state();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) drive(1'b1, 4'b1111, 4'd1, 32'hDEADBEEF, 1'b1, 4'd1, 1'b0, 32'h0, 32'h0);
            else        idle();
        end
        pulse_rst();
        check_reset_state();
        count_busy(16);
        rd(4'd1, 32'h0);
        rd(4'd3, 32'h0);
        rd(4'd6, 32'h0);
        repeat (3) idle();

        // Reset the cycle after a read: u0 still has it in flight, u1 has already delivered it.
        wr(4'd1, 4'b1111, 32'h5A5A5A5A);
        rd(4'd1, 32'h5A5A5A5A);
        pulse_rst();
        check_reset_state();
        count_busy(16);
        repeat (3) idle();

        chk("u0_scoreboard_empty", 32'(q0.size()), 32'd0);
        chk("u1_scoreboard_empty", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
